// File: rtl/rr_arb_mux.sv
// rr_arb_mux
// ----------
// Registered N-to-1 data multiplexer with round-robin arbitration and
// valid/ready handshaking on every channel. Several producers contend for a
// single consumer; one beat per cycle is moved from the granted producer into
// a single output register, and the search for the next producer starts just
// past the channel that was served last, so every persistent requester is
// served within NUM_IN accepted beats.
//
// Parameters
//   WIDTH   data width of each channel in bits
//   NUM_IN  number of input channels (2..16, any value in that range)
//   SEL_W   width of the source index, derived from NUM_IN (leave as is)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel "beat available"
//   in_ready   per-channel "beat accepted this cycle" (at most one high)
//   out_data   registered selected beat
//   out_valid  out_data holds a beat the consumer has not taken yet
//   out_ready  consumer takes the beat this cycle
//   out_src    index of the channel that produced out_data

module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  // Architectural state: the output register and the round-robin pointer.
  logic [WIDTH-1:0]  r_outData;
  logic [SEL_W-1:0]  r_outSrc;
  logic              r_outValid;
  logic [SEL_W-1:0]  r_ptr;

  // Arbitration results.
  logic              w_loadEn;
  logic              w_grantAny;
  logic [SEL_W-1:0]  w_grantIdx;
  logic [NUM_IN-1:0] w_grantVec;
  logic [WIDTH-1:0]  w_selData;
  logic              w_inXfer;
  logic [SEL_W-1:0]  w_nextPtr;
  int                w_scanIdx;

  // The output register can take a new beat when it is empty or when its
  // current beat is leaving in this same cycle (full throughput).
  assign w_loadEn = !r_outValid || out_ready;

  // Rotating priority search: visit ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1
  // and grant the first requester found. The index is wrapped explicitly so
  // non-power-of-two channel counts never produce an out-of-range grant.
  always_comb begin
    w_grantAny = 1'b0;
    w_grantIdx = '0;
    w_grantVec = '0;
    w_scanIdx  = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_scanIdx = int'(r_ptr) + k;
      if (w_scanIdx >= NUM_IN) begin
        w_scanIdx = w_scanIdx - NUM_IN;
      end
      if (!w_grantAny && in_valid[w_scanIdx]) begin
        w_grantAny            = 1'b1;
        w_grantIdx            = SEL_W'(w_scanIdx);
        w_grantVec[w_scanIdx] = 1'b1;
      end
    end
  end

  // One-hot AND-OR data select driven by the grant vector; in_ready never
  // looks at the data, only this path does.
  always_comb begin
    w_selData = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_grantVec[i]) begin
        w_selData = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is suppressed during reset so a handshake presented while reset is
  // held is never considered accepted by the producer.
  assign in_ready = (w_loadEn && !rst) ? w_grantVec : '0;
  assign w_inXfer = w_loadEn && w_grantAny && !rst;

  // Next pointer sits just past the served channel, wrapping at NUM_IN-1.
  assign w_nextPtr = (w_grantIdx == SEL_W'(NUM_IN - 1)) ? '0 : w_grantIdx + 1'b1;

  // Output register and pointer update. A new beat overrides a drain in the
  // same cycle; a drain alone only clears valid and keeps data/src visible.
  // The pointer moves only when a beat is actually accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outData  <= '0;
      r_outSrc   <= '0;
      r_outValid <= 1'b0;
      r_ptr      <= '0;
    end else if (w_inXfer) begin
      r_outData  <= w_selData;
      r_outSrc   <= w_grantIdx;
      r_outValid <= 1'b1;
      r_ptr      <= w_nextPtr;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_data  = r_outData;
  assign out_src   = r_outSrc;
  assign out_valid = r_outValid;

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised, registered N-to-1 data multiplexer with round-robin arbitration and valid/ready handshaking on every channel. It generalises the core's fixed 2/4/5-input 32-bit combinational selectors into a W-bit, N-channel block. Several producers (e.g. fetch, load/store, debug/UART paths) contend for one shared consumer, and the block guarantees fairness, lossless back-pressure and a single registered output stage.

## Interface
- WIDTH, 32, data width per channel in bits (≥1)
- NUM_IN, 4, number of input channels (2..16; need not be a power of two)
- SEL_W, $clog2(NUM_IN), width of the source index (derived; do not override)

Clocking and reset are fixed: one clock, and reset is synchronous and active-high.

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  channel i has a beat
- in_ready  output  NUM_IN  channel i beat is accepted this cycle
- out_data  output  WIDTH  registered selected beat
- out_valid  output  1  out_data holds an unconsumed beat
- out_ready  input  1  consumer accepts the beat
- out_src  output  SEL_W  index of the channel that produced out_data

## Operation
- State: output register (out_data, out_src, out_valid) and a round-robin pointer ptr (SEL_W bits).
- load_en = !out_valid || out_ready. The register is empty, or is being drained this cycle.
- Grant (combinational): the first i with in_valid[i]=1, searching ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1. Indices ≥ NUM_IN are never granted. At most one grant bit is set.
- in_ready[i] = load_en && grant[i] && !rst. At most one in_ready is high per cycle. in_ready[i] never depends on in_data.
- Input transfer on channel i (in_valid[i] && in_ready[i]):
  - out_data ← in_data[i]
  - out_src ← i
  - out_valid ← 1
  - ptr ← (i+1) mod NUM_IN, wrapping from NUM_IN-1 to 0
- Output transfer (out_valid && out_ready) with no input transfer in the same cycle: out_valid ← 0. out_data and out_src keep their last values.
- Simultaneous output and input transfer: the new beat replaces the old one. out_valid stays 1, giving full throughput of one beat per cycle.
- Stall (out_valid && !out_ready): all in_ready=0; out_data, out_src and ptr hold; no beat is lost or duplicated.
- No transfer: ptr holds. The pointer advances only on an accepted beat.
- Fairness: a channel holding in_valid continuously is granted within NUM_IN accepted beats.
- Reset: out_valid=0, out_data=0, out_src=0, ptr=0, and all in_ready=0 while rst=1. Reset mid-transfer discards the registered beat. Any input handshake presented during the reset cycle is not accepted.

## Timing
- Latency: an input accepted at edge k appears on out_data/out_valid right after edge k (1 cycle).
- Throughput: 1 beat/cycle while out_ready=1 and any in_valid=1.
- Combinational paths:
  - in_valid[*] and out_ready → in_ready[*]
  - No combinational path from any input to out_data, out_valid or out_src; these are register outputs.
- The first beat after reset deassertion can be accepted in the first cycle with rst=0.

## Test plan
- Reset and idle: assert rst for 2 cycles with all in_valid=1 → in_ready=0, out_valid=0, out_data=0, out_src=0. Deassert rst → in_ready=4'b0001 in the first cycle, then out_valid=1 and out_src=0 on the next cycle.
- Round-robin fairness (NUM_IN=4, WIDTH=32): all four in_valid held high, in_data[i]=32'hA0+i, out_ready=1 → out_src sequence 0,1,2,3,0,1…, out_data A0,A1,A2,A3,A0…, one beat per cycle.
- Back-pressure: one beat from ch2 (32'hDEAD_BEEF), then out_ready=0 for 5 cycles with ch0 and ch1 valid → out_data=DEADBEEF and out_src=2 stable, all in_ready=0. On out_ready=1 the next grant is ch0 (ptr wrapped 3→0) in the same cycle.
- Sparse traffic: only ch3 valid, one beat every 3 cycles → every beat forwarded with 1-cycle latency, out_src=3. out_valid drops between beats when out_ready=1.
- Non-power-of-two (NUM_IN=3): all valid → out_src cycles 0,1,2,0, never 3, and ptr wraps 2→0.
- Reset mid-stream: rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0 and ptr=0. After release, ch0 is granted first even if it was not next in rotation.
